btb_ras_predictor: RTL and testbench

- Next-generation control-flow target unit: moves target prediction from EX into fetch.
- Direct-mapped branch target buffer (BTB) with 2-bit saturating direction counters, plus a circular return-address stack (RAS).
- Fetch side: combinational lookup on the fetch PC gives predicted taken/target. EX side: resolved outcomes train the BTB and push/pop the RAS, non-speculatively.
- Generalises the single-cycle target adders in width, entry count and RAS depth.

---
 rtl/bp_pkg.sv | 22 ++
 rtl/ras_stack.sv | 59 +++++
 rtl/btb_ras_predictor.sv | 127 ++++++++++++
 tb/tb_btb_ras_predictor.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared encodings for the fetch-stage target predictor: BTB entry types,
// 2-bit direction counter states and the saturating counter update.
package bp_pkg;

  typedef enum logic [1:0] {
    BT_BR   = 2'd0,
    BT_JAL  = 2'd1,
    BT_JALR = 2'd2,
    BT_RET  = 2'd3
  } btype_e;

  localparam logic [1:0] SNT = 2'd0;
  localparam logic [1:0] WNT = 2'd1;
  localparam logic [1:0] WT  = 2'd2;
  localparam logic [1:0] ST  = 2'd3;

  function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic taken);
    if (taken) return (c == ST)  ? ST  : c + 2'd1;
    else       return (c == SNT) ? SNT : c - 2'd1;
  endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: a full push overwrites the oldest slot,
// an empty pop is ignored, and push+pop together replaces the top in place.
module ras_stack #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [XLEN-1:0]              push_data,
  output logic [XLEN-1:0]              top,
  output logic [$clog2(RAS_DEPTH):0]   count
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(RAS_DEPTH);

  logic [RAS_DEPTH-1:0][XLEN-1:0] mem_q;
  logic [PW-1:0] sp_q, sp_d, top_idx, wr_idx;
  logic [PW:0]   cnt_q, cnt_d;
  logic          wr;

  // sp_q is the next free slot, so the top lives one below it
  assign top_idx = sp_q - 1'b1;
  assign top     = mem_q[top_idx];
  assign count   = cnt_q;

  always_comb begin
    sp_d   = sp_q;
    cnt_d  = cnt_q;
    wr     = 1'b0;
    wr_idx = sp_q;
    if (push && pop && cnt_q != '0) begin
      wr     = 1'b1;
      wr_idx = top_idx;
    end else if (push) begin
      wr   = 1'b1;
      sp_d = sp_q + 1'b1;
      if (cnt_q != FULL) cnt_d = cnt_q + 1'b1;
    end else if (pop && cnt_q != '0) begin
      sp_d  = sp_q - 1'b1;
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '0;
      sp_q  <= '0;
      cnt_q <= '0;
    end else begin
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
      if (wr) mem_q[wr_idx] <= push_data;
    end
  end

endmodule

// File: rtl/btb_ras_predictor.sv
// Fetch-stage target predictor: direct-mapped BTB with 2-bit counters plus a
// return-address stack, trained non-speculatively from resolved EX outcomes.
module btb_ras_predictor
  import bp_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BTB_ENTRIES = 16,
  parameter int RAS_DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [XLEN-1:0]             if_pc,
  output logic                        pred_taken,
  output logic [XLEN-1:0]             pred_target,
  input  logic                        ex_valid,
  input  logic [XLEN-1:0]             ex_pc,
  input  logic                        ex_is_branch,
  input  logic                        ex_is_jal,
  input  logic                        ex_is_jalr,
  input  logic                        ex_is_call,
  input  logic                        ex_is_ret,
  input  logic                        ex_taken,
  input  logic [XLEN-1:0]             ex_target,
  output logic [$clog2(RAS_DEPTH):0]  ras_count
);

  localparam int IW = $clog2(BTB_ENTRIES);
  localparam int TW = XLEN - IW - 2;

  logic [BTB_ENTRIES-1:0]             valid_q;
  logic [BTB_ENTRIES-1:0][TW-1:0]     tag_q;
  logic [BTB_ENTRIES-1:0][XLEN-2:0]   tgt_q;
  logic [BTB_ENTRIES-1:0][1:0]        typ_q;
  logic [BTB_ENTRIES-1:0][1:0]        ctr_q;

  logic [XLEN-1:0] ras_top;
  logic [IW-1:0]   l_idx, u_idx;
  logic [TW-1:0]   l_tag, u_tag;
  logic            l_hit, u_hit, upd;
  btype_e          u_typ;
  logic            wr_en_d, wr_tgt_d;
  logic [1:0]      wr_ctr_d;
  logic            unused_ok;

  assign unused_ok = ^{if_pc[1:0], ex_target[0]};

  ras_stack #(.XLEN(XLEN), .RAS_DEPTH(RAS_DEPTH)) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (ex_valid && ex_is_call),
    .pop       (ex_valid && ex_is_ret),
    .push_data (ex_pc + XLEN'(4)),
    .top       (ras_top),
    .count     (ras_count)
  );

  // Lookup reads state registers only, so a same-cycle write is not visible
  assign l_idx = if_pc[IW+1:2];
  assign l_tag = if_pc[XLEN-1:IW+2];
  assign l_hit = valid_q[l_idx] && (tag_q[l_idx] == l_tag);

  always_comb begin
    pred_taken  = 1'b0;
    pred_target = '0;
    if (l_hit) begin
      case (btype_e'(typ_q[l_idx]))
        BT_BR: begin
          pred_taken  = ctr_q[l_idx][1];
          pred_target = {tgt_q[l_idx], 1'b0};
        end
        BT_JAL, BT_JALR: begin
          pred_taken  = 1'b1;
          pred_target = {tgt_q[l_idx], 1'b0};
        end
        default: begin
          pred_taken  = (ras_count != '0);
          pred_target = ras_top;
        end
      endcase
    end
  end

  assign u_idx = ex_pc[IW+1:2];
  assign u_tag = ex_pc[XLEN-1:IW+2];
  assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
  assign upd   = ex_valid && (ex_is_branch || ex_is_jal || ex_is_jalr);
  assign u_typ = ex_is_ret ? BT_RET : ex_is_jalr ? BT_JALR : ex_is_jal ? BT_JAL : BT_BR;

  always_comb begin
    wr_en_d  = 1'b0;
    wr_tgt_d = 1'b0;
    wr_ctr_d = ST;
    if (upd) begin
      if (u_typ == BT_BR) begin
        if (u_hit) begin
          wr_en_d  = 1'b1;
          wr_tgt_d = ex_taken;
          wr_ctr_d = ctr_next(ctr_q[u_idx], ex_taken);
        end else if (ex_taken) begin
          wr_en_d  = 1'b1;
          wr_tgt_d = 1'b1;
          wr_ctr_d = WT;
        end
      end else begin
        wr_en_d  = 1'b1;
        wr_tgt_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      tag_q   <= '0;
      tgt_q   <= '0;
      typ_q   <= '0;
      ctr_q   <= '0;
    end else if (wr_en_d) begin
      valid_q[u_idx] <= 1'b1;
      tag_q[u_idx]   <= u_tag;
      typ_q[u_idx]   <= u_typ;
      ctr_q[u_idx]   <= wr_ctr_d;
      if (wr_tgt_d) tgt_q[u_idx] <= ex_target[XLEN-1:1];
    end
  end

endmodule

// File: tb/tb_btb_ras_predictor.sv
// Directed bench for btb_ras_predictor: BTB training, aliasing, RAS wrap/underflow,
// same-cycle call+ret, no-bypass lookup and asynchronous reset.
module tb_btb_ras_predictor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] if_pc = '0;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid = 1'b0;
  logic [31:0] ex_pc = '0;
  logic        ex_is_branch = 1'b0, ex_is_jal = 1'b0, ex_is_jalr = 1'b0;
  logic        ex_is_call = 1'b0, ex_is_ret = 1'b0, ex_taken = 1'b0;
  logic [31:0] ex_target = '0;
  logic [2:0]  ras_count;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  btb_ras_predictor #(.XLEN(32), .BTB_ENTRIES(16), .RAS_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .if_pc(if_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_is_branch(ex_is_branch), .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr),
    .ex_is_call(ex_is_call), .ex_is_ret(ex_is_ret), .ex_taken(ex_taken),
    .ex_target(ex_target), .ras_count(ras_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic drive_ex(input logic [31:0] pc, input logic [31:0] tgt,
                          input logic br, input logic jal, input logic jalr,
                          input logic call, input logic ret, input logic tk);
    ex_valid = 1'b1; ex_pc = pc; ex_target = tgt;
    ex_is_branch = br; ex_is_jal = jal; ex_is_jalr = jalr;
    ex_is_call = call; ex_is_ret = ret; ex_taken = tk;
  endtask

  task automatic clr_ex();
    ex_valid = 1'b0; ex_is_branch = 1'b0; ex_is_jal = 1'b0; ex_is_jalr = 1'b0;
    ex_is_call = 1'b0; ex_is_ret = 1'b0; ex_taken = 1'b0;
  endtask

  // one resolved instruction, applied across a single rising edge
  task automatic ex_op(input logic [31:0] pc, input logic [31:0] tgt,
                       input logic br, input logic jal, input logic jalr,
                       input logic call, input logic ret, input logic tk);
    @(negedge clk);
    drive_ex(pc, tgt, br, jal, jalr, call, ret, tk);
    @(negedge clk);
    clr_ex();
  endtask

  task automatic look(input logic [31:0] pc);
    if_pc = pc;
    #1;
  endtask

  initial begin
    #12;
    chk("rst_taken", 64'(pred_taken), 64'd0);
    chk("rst_target", 64'(pred_target), 64'd0);
    chk("rst_count", 64'(ras_count), 64'd0);
    @(negedge clk); rst = 1'b0;
    look(32'h100);
    chk("post_rst_taken", 64'(pred_taken), 64'd0);
    chk("post_rst_target", 64'(pred_target), 64'd0);

    // branch training: alloc ctr=2, then 3, then down to 1
    ex_op(32'h100, 32'h80, 1, 0, 0, 0, 0, 1); look(32'h100);
    chk("br_alloc_taken", 64'(pred_taken), 64'd1);
    chk("br_alloc_target", 64'(pred_target), 64'h80);
    ex_op(32'h100, 32'h80, 1, 0, 0, 0, 0, 1);
    ex_op(32'h100, 32'h80, 1, 0, 0, 0, 0, 0); look(32'h100);
    chk("br_ctr2_taken", 64'(pred_taken), 64'd1);
    ex_op(32'h100, 32'h80, 1, 0, 0, 0, 0, 0); look(32'h100);
    chk("br_ctr1_taken", 64'(pred_taken), 64'd0);
    for (int i = 0; i < 5; i++) ex_op(32'h100, 32'h80, 1, 0, 0, 0, 0, 1);
    ex_op(32'h100, 32'h80, 1, 0, 0, 0, 0, 0); look(32'h100);
    chk("br_sat_nt1", 64'(pred_taken), 64'd1);
    ex_op(32'h100, 32'h80, 1, 0, 0, 0, 0, 0); look(32'h100);
    chk("br_sat_nt2", 64'(pred_taken), 64'd0);
    ex_op(32'h100, 32'h90, 1, 0, 0, 0, 0, 1); look(32'h100);
    chk("br_retarget_taken", 64'(pred_taken), 64'd1);
    chk("br_retarget_target", 64'(pred_target), 64'h90);
    ex_op(32'h104, 32'h88, 1, 0, 0, 0, 0, 0); look(32'h104);
    chk("br_miss_nt_noalloc", 64'(pred_taken), 64'd0);

    // aliasing on idx 0
    ex_op(32'h100, 32'h200, 0, 1, 0, 0, 0, 0); look(32'h100);
    chk("jal_target", 64'(pred_target), 64'h200);
    ex_op(32'h140, 32'h300, 0, 1, 0, 0, 0, 0); look(32'h100);
    chk("alias_evict_taken", 64'(pred_taken), 64'd0);
    chk("alias_evict_target", 64'(pred_target), 64'd0);
    look(32'h140);
    chk("alias_new_taken", 64'(pred_taken), 64'd1);
    chk("alias_new_target", 64'(pred_target), 64'h300);

    ex_op(32'h18C, 32'h1234, 0, 0, 1, 0, 0, 0); look(32'h18C);
    chk("jalr_taken", 64'(pred_taken), 64'd1);
    chk("jalr_target", 64'(pred_target), 64'h1234);

    // RET entry trained while RAS is empty: prediction suppressed
    ex_op(32'h208, 32'h0, 0, 0, 1, 0, 1, 0); look(32'h208);
    chk("ret_empty_taken", 64'(pred_taken), 64'd0);
    chk("ret_empty_count", 64'(ras_count), 64'd0);

    ex_op(32'h10, 32'h400, 0, 1, 0, 1, 0, 0);
    ex_op(32'h20, 32'h400, 0, 1, 0, 1, 0, 0);
    ex_op(32'h30, 32'h400, 0, 1, 0, 1, 0, 0);
    chk("ras_count3", 64'(ras_count), 64'd3);
    ex_op(32'h40, 32'h400, 0, 1, 0, 1, 0, 0);
    ex_op(32'h50, 32'h400, 0, 1, 0, 1, 0, 0);
    chk("ras_full_count", 64'(ras_count), 64'd4);
    look(32'h208);
    chk("ret_pred_taken", 64'(pred_taken), 64'd1);
    chk("ret_pred_top", 64'(pred_target), 64'h54);

    ex_op(32'h208, 32'h54, 0, 0, 1, 0, 1, 0); look(32'h208);
    chk("pop1_top", 64'(pred_target), 64'h44);
    chk("pop1_count", 64'(ras_count), 64'd3);
    ex_op(32'h208, 32'h44, 0, 0, 1, 0, 1, 0); look(32'h208);
    chk("pop2_top", 64'(pred_target), 64'h34);
    ex_op(32'h208, 32'h34, 0, 0, 1, 0, 1, 0); look(32'h208);
    chk("pop3_top", 64'(pred_target), 64'h24);
    chk("pop3_count", 64'(ras_count), 64'd1);

    // call+ret together replaces top
    ex_op(32'h60, 32'h24, 0, 0, 1, 1, 1, 0); look(32'h208);
    chk("callret_top", 64'(pred_target), 64'h64);
    chk("callret_count", 64'(ras_count), 64'd1);

    ex_op(32'h208, 32'h64, 0, 0, 1, 0, 1, 0);
    chk("pop4_count", 64'(ras_count), 64'd0);
    ex_op(32'h208, 32'h0, 0, 0, 1, 0, 1, 0); look(32'h208);
    chk("pop_empty_count", 64'(ras_count), 64'd0);
    chk("pop_empty_suppress", 64'(pred_taken), 64'd0);

    // write to idx 0 while looking up the old idx-0 occupant
    @(negedge clk);
    drive_ex(32'h300, 32'h500, 0, 1, 0, 0, 0, 0);
    look(32'h40);
    chk("nobypass_old_taken", 64'(pred_taken), 64'd1);
    chk("nobypass_old_target", 64'(pred_target), 64'h400);
    @(negedge clk); clr_ex();
    look(32'h40);
    chk("after_wr_old_miss", 64'(pred_taken), 64'd0);
    look(32'h300);
    chk("after_wr_new_target", 64'(pred_target), 64'h500);

    // push of 0xFFFFFFFC+4 wraps to 0
    ex_op(32'hFFFF_FFFC, 32'h0, 0, 0, 0, 1, 0, 0); look(32'h208);
    chk("wrap_count", 64'(ras_count), 64'd1);
    chk("wrap_taken", 64'(pred_taken), 64'd1);
    chk("wrap_top", 64'(pred_target), 64'd0);

    // asynchronous reset between edges
    @(negedge clk);
    look(32'h300);
    chk("pre_arst_taken", 64'(pred_taken), 64'd1);
    rst = 1'b1;
    #1;
    chk("arst_taken", 64'(pred_taken), 64'd0);
    chk("arst_target", 64'(pred_target), 64'd0);
    chk("arst_count", 64'(ras_count), 64'd0);
    @(negedge clk); rst = 1'b0;
    look(32'h18C);
    chk("arst_cleared_jalr", 64'(pred_taken), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
